rot_dma_master: RTL

Downstream consumer of the rotate core's address generator. Accepts one transfer command per handshake (address, size, direction, beat count) and executes it as an AHB-Lite INCR burst. Read data lands in an internal pixel FIFO; write bursts drain that FIFO. This moves each source pixel block to its rotated destination. It drives I_DMA_READY of the address generator through O_DMA_READY.

---
 rtl/rot_dma_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rot_dma_master.sv
// rtl/rot_dma_master.sv - AHB-Lite INCR burst DMA master with pixel FIFO; optional ROT_DMA_KB_SPLIT_EN
module rot_dma_master #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic                   I_HCLK,
  input  logic                   I_HRESET_N,
  input  logic                   I_CMD_VALID,
  input  logic [AW-1:0]          I_ADDR,
  input  logic [2:0]             I_SIZE,
  input  logic                   I_WRITE,
  input  logic [4:0]             I_COUNT,
  output logic                   O_DMA_READY,
  output logic [AW-1:0]          O_HADDR,
  output logic [1:0]             O_HTRANS,
  output logic                   O_HWRITE,
  output logic [2:0]             O_HSIZE,
  output logic [2:0]             O_HBURST,
  output logic [31:0]            O_HWDATA,
  input  logic [31:0]            I_HRDATA,
  input  logic                   I_HREADY,
  input  logic                   I_HRESP,
  output logic                   O_BUSY,
  output logic                   O_ERROR,
  output logic [$clog2(DEPTH):0] O_FIFO_LEVEL
);

  localparam int LW   = $clog2(DEPTH);
  localparam int LVLW = LW + 1;

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic            write_q, write_d;
  // Full beat count while waiting, then address phases still to issue.
  logic [4:0]      beats_q, beats_d;
  logic            first_q, first_d;
  // A data phase is outstanding on the bus.
  logic            dp_q, dp_d;
  logic            error_q, error_d;

  logic [31:0]     mem_q [DEPTH];
  logic [LW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVLW-1:0] level_q;

  logic            active;
  logic            data_err;
  logic            data_ok;
  logic            addr_acc;
  logic            push;
  logic            pop;
  logic            fifo_ok;
  logic [4:0]      beats_in;
  logic [AW-1:0]   addr_inc;

  assign active   = (state_q == S_ADDR) || (state_q == S_DATA);
  assign data_err = active && dp_q && I_HRESP;
  assign data_ok  = active && dp_q && I_HREADY && !I_HRESP;
  assign addr_acc = (state_q == S_ADDR) && I_HREADY && !data_err;
  assign push     = data_ok && !write_q;
  // An errored write beat still consumes its FIFO word.
  assign pop      = active && dp_q && write_q && (I_HREADY || I_HRESP);
  assign beats_in = (I_COUNT == 5'd0) ? 5'd1 : I_COUNT;
  assign addr_inc = AW'(1) << size_q;
  // The whole burst must fit before it starts, so the FIFO never over/underflows.
  assign fifo_ok  = write_q ? (level_q >= LVLW'(beats_q))
                            : ((LVLW'(DEPTH) - level_q) >= LVLW'(beats_q));

  // State register
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (I_CMD_VALID) state_d = S_WAIT;
      S_WAIT: if (fifo_ok) state_d = S_ADDR;
      S_ADDR: begin
        if (data_err)                          state_d = S_ERR;
        else if (I_HREADY && beats_q == 5'd1)  state_d = S_DATA;
      end
      S_DATA: begin
        if (data_err)      state_d = S_ERR;
        else if (I_HREADY) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    O_DMA_READY = (state_q == S_IDLE) && I_HRESET_N;
    O_BUSY      = (state_q == S_WAIT) || active;
    O_HTRANS    = HT_IDLE;
    if (state_q == S_ADDR) begin
      O_HTRANS = first_q ? HT_NONSEQ : HT_SEQ;
`ifdef ROT_DMA_KB_SPLIT_EN
      if (addr_q[9:0] == 10'd0) O_HTRANS = HT_NONSEQ;
`endif
    end
    O_HWDATA = (active && dp_q && write_q) ? mem_q[rd_ptr_q] : 32'd0;
  end

  assign O_HADDR      = addr_q;
  assign O_HWRITE     = write_q;
  assign O_HSIZE      = size_q;
  assign O_HBURST     = 3'd1;
  assign O_ERROR      = error_q;
  assign O_FIFO_LEVEL = level_q;

  // Command and burst-progress next-state values
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    beats_d = beats_q;
    first_d = first_q;
    dp_d    = dp_q;
    error_d = error_q;
    if (state_q == S_IDLE && I_CMD_VALID) begin
      addr_d  = I_ADDR;
      size_d  = I_SIZE;
      write_d = I_WRITE;
      beats_d = beats_in;
      first_d = 1'b1;
      dp_d    = 1'b0;
    end
    if (addr_acc) begin
      addr_d  = addr_q + addr_inc;
      beats_d = beats_q - 5'd1;
      first_d = 1'b0;
      dp_d    = 1'b1;
    end else if (data_ok) begin
      dp_d = 1'b0;
    end
    if (data_err) begin
      dp_d    = 1'b0;
      error_d = 1'b1;
    end
  end

  // Command and burst-progress registers
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      addr_q  <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      beats_q <= 5'd0;
      first_q <= 1'b0;
      dp_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      beats_q <= beats_d;
      first_q <= first_d;
      dp_q    <= dp_d;
      error_q <= error_d;
    end
  end

  // FIFO pointers and occupancy; push and pop are mutually exclusive
  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + LW'(1);
      level_q  <= level_q + LVLW'(1);
    end else if (pop) begin
      rd_ptr_q <= rd_ptr_q + LW'(1);
      level_q  <= level_q - LVLW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge I_HCLK) begin
    if (push) mem_q[wr_ptr_q] <= I_HRDATA;
  end

endmodule
